uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmit stage that produces the line consumed by the team's UART receiver. It accepts one 8-bit byte through a valid/ready handshake and generates its own bit timing from `clk`. It shifts out a frame of start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits on `tx`. Status outputs `transmitting` and `transmitted` drive the receiver's inputs of the same names.

## Interface
- `CLKS_PER_BIT`, 5208: `clk` cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled only on acceptance.
- `tx_valid`  in  1  byte on `tx_data` is offered.
- `tx_ready`  out  1  block can accept a byte (registered).
- `tx`  out  1  serial line; idle/mark = 1.
- `transmitting`  out  1  high while a frame is on the line.
- `transmitted`  out  1  one-cycle pulse at frame completion.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `transmitting`=0, `transmitted`=0; state IDLE, counters 0, shift register 0.
- Acceptance: at a rising edge where `tx_valid`=1 and `tx_ready`=1. `tx_data` is latched into the shift register and parity is computed from the latched byte.
- `tx_valid` while `tx_ready`=0 is ignored; there is no queueing. `tx_data` changes while busy have no effect.
- FSM states: IDLE → START → DATA → (PARITY if `PARITY_EN`) → STOP → IDLE.
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift[0]; shift right one place at each bit boundary.
  - PARITY: even parity bit = ^data; odd parity bit = ~^data.
  - STOP: `tx`=1 for `STOP_BITS` bit periods.
- Baud counter: 0..`CLKS_PER_BIT`-1, width $clog2(`CLKS_PER_BIT`). It clears on acceptance and wraps at each bit boundary.
- Bit index: 0..7 in DATA; 0..`STOP_BITS`-1 in STOP. Advances only at a bit boundary.
- Frame length: F = 1 + 8 + `PARITY_EN` + `STOP_BITS` bits.
- Reset mid-frame: abort the frame at the next edge and return all outputs to their reset values. No `transmitted` pulse is issued; the partial frame is discarded.

## Timing
- Let E0 be the accepting edge.
- After E0: `tx`=0, `transmitting`=1, `tx_ready`=0.
- Bit k of the frame (k=0 is the start bit) is driven from edge E(k·C) to edge E((k+1)·C), where C=`CLKS_PER_BIT`. The line changes only on these edges, so each bit is exactly C cycles wide with no glitches.
- At edge E(F·C):
  - state returns to IDLE; `tx`=1 (already 1); `transmitting`=0; `tx_ready`=1;
  - `transmitted`=1 for exactly one cycle, cleared at the next edge.
- Back-to-back: the earliest next acceptance is edge E(F·C+1), giving a 1-cycle idle gap. The sustained frame period is F·C+1 cycles.
- Latency from acceptance to the first start-bit cycle on `tx` is 1 edge.

## Test plan
- **Basic frame.** C=4, no parity, 1 stop bit; send 0xA5.
  - `tx` is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
  - `transmitted` pulses at E40; `tx_ready` is back to 1 at E40.
- **Even parity.** C=4, `PARITY_EN`=1, `PARITY_ODD`=0, `STOP_BITS`=2.
  - Send 0x07: parity bit = 1; frame is 12 bits; `transmitted` pulses at E48.
  - Send 0x03: parity bit = 0.
- **Back-to-back.** Hold `tx_valid`=1 with 0x55 then 0x0F.
  - Second acceptance occurs at E41 with `tx`=1 during cycle 40–41.
  - Second frame is bit-exact.
  - Exactly 2 `transmitted` pulses.
- **Ignored offer while busy.** Pulse `tx_valid` with 0xFF mid-frame while sending 0x00.
  - Only the 0x00 frame appears; `tx_data` changes mid-frame do not alter the bits.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3.
  - At the next edge: `tx`=1, `tx_ready`=1, `transmitting`=0, no `transmitted` pulse.
  - A subsequent 0x3C frame is correct.
- **Loopback.** Drive the receiver's `rx` from `tx`, with the receiver's baud tick aligned to the bit centres.
  - Bytes 0x00, 0xFF, 0x5A, 0x81 are recovered in order; receiver `received` pulses once per frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit stage: valid/ready byte input, start + 8 data bits (LSB first),
// optional parity and 1 or 2 stop bits on a registered serial line.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       transmitting,
  output logic       transmitted
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic           PAR_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [7:0] data);
    return (PARITY_ODD != 0) ? ~^data : ^data;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             parity_r, parity_s;
  logic             tx_r, tx_s;
  logic             tx_ready_r, tx_ready_s;
  logic             transmitting_r, transmitting_s;
  logic             transmitted_r, transmitted_s;
  logic             bit_end_s;

  assign bit_end_s = (baud_cnt_r == CNT_LAST);

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      baud_cnt_r     <= CNT_ZERO;
      bit_idx_r      <= 3'd0;
      shift_r        <= 8'd0;
      parity_r       <= 1'b0;
      tx_r           <= 1'b1;
      tx_ready_r     <= 1'b1;
      transmitting_r <= 1'b0;
      transmitted_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      baud_cnt_r     <= baud_cnt_s;
      bit_idx_r      <= bit_idx_s;
      shift_r        <= shift_s;
      parity_r       <= parity_s;
      tx_r           <= tx_s;
      tx_ready_r     <= tx_ready_s;
      transmitting_r <= transmitting_s;
      transmitted_r  <= transmitted_s;
    end
  end

  // Next-state logic; tx_s is the value the line takes after the edge.
  always_comb begin
    state_s        = state_r;
    baud_cnt_s     = bit_end_s ? CNT_ZERO : (baud_cnt_r + CNT_ONE);
    bit_idx_s      = bit_idx_r;
    shift_s        = shift_r;
    parity_s       = parity_r;
    tx_s           = tx_r;
    tx_ready_s     = tx_ready_r;
    transmitting_s = transmitting_r;
    transmitted_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        baud_cnt_s     = CNT_ZERO;
        bit_idx_s      = 3'd0;
        tx_s           = 1'b1;
        tx_ready_s     = 1'b1;
        transmitting_s = 1'b0;
        if (tx_valid && tx_ready_r) begin
          shift_s        = tx_data;
          parity_s       = parity_bit(tx_data);
          state_s        = ST_START;
          tx_s           = 1'b0;
          tx_ready_s     = 1'b0;
          transmitting_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          bit_idx_s = 3'd0;
          tx_s      = shift_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            if (PAR_EN) begin
              state_s = ST_PARITY;
              tx_s    = parity_r;
            end else begin
              state_s = ST_STOP;
              tx_s    = 1'b1;
            end
          end else begin
            // Bit 1 of the current shift value becomes bit 0 after the shift.
            bit_idx_s = bit_idx_r + 3'd1;
            shift_s   = {1'b0, shift_r[7:1]};
            tx_s      = shift_r[1];
          end
        end else begin
          tx_s = shift_r[0];
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          state_s   = ST_STOP;
          bit_idx_s = 3'd0;
          tx_s      = 1'b1;
        end else begin
          tx_s = parity_r;
        end
      end

      ST_STOP: begin
        tx_s = 1'b1;
        if (bit_end_s) begin
          if (bit_idx_r == STOP_LAST) begin
            state_s        = ST_IDLE;
            bit_idx_s      = 3'd0;
            tx_ready_s     = 1'b1;
            transmitting_s = 1'b0;
            transmitted_s  = 1'b1;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          bit_idx_s = bit_idx_r;
        end
      end

      default: begin
        state_s        = ST_IDLE;
        baud_cnt_s     = CNT_ZERO;
        bit_idx_s      = 3'd0;
        tx_s           = 1'b1;
        tx_ready_s     = 1'b1;
        transmitting_s = 1'b0;
      end
    endcase
  end

  assign tx_ready     = tx_ready_r;
  assign tx           = tx_r;
  assign transmitting = transmitting_r;
  assign transmitted  = transmitted_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three configurations checked cycle by cycle
// against a frame model built from the bit-level framing rules.
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [2:0] tx_valid;
  logic [7:0] tx_data [3];
  logic [2:0] tx_ready_w, tx_w, transmitting_w, transmitted_w;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic samp_q [$];

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .transmitting(transmitting_w[0]),
    .transmitted(transmitted_w[0]));

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .transmitting(transmitting_w[1]),
    .transmitted(transmitted_w[1]));

  uart_transmitter #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .transmitting(transmitting_w[2]),
    .transmitted(transmitted_w[2]));

  function automatic int cfg_c(input int d);
    case (d)
      0: return 4;
      1: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_par(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int cfg_odd(input int d);
    return (d == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_stop(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return 9 + cfg_par(d) + cfg_stop(d);
  endfunction

  // Bit k of the frame: start, data LSB first, optional parity, stop bits.
  function automatic logic frame_bit(input int d, input logic [7:0] data, input int k);
    logic p;
    if (k == 0) return 1'b0;
    if (k <= 8) return data[k-1];
    if (cfg_par(d) == 1 && k == 9) begin
      p = (($countones(data) % 2) == 1);
      return (cfg_odd(d) == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (transmitted_w[i] === 1'b1) done_cnt[i]++;
    end
  end

  task automatic offer(input int d, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready_w[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("d%0d_ready_wait", d), 32'(tx_ready_w[d]), 32'd1);
    tx_valid[d] = 1'b1;
    tx_data[d]  = data;
  endtask

  // Caller has presented the byte; the next rising edge is the accepting edge.
  task automatic run_frame(input int d, input logic [7:0] data, input bit chain,
                           input logic [7:0] nxt, input bit glitch);
    int c, f, nc, gj;
    logic [7:0] got_b;
    c  = cfg_c(d);
    f  = frame_len(d);
    nc = c * f;
    gj = glitch ? $urandom_range(nc - 3, 1) : -5;
    samp_q.delete();
    @(posedge clk);
    for (int n = 0; n < nc; n++) begin
      @(negedge clk);
      if (n == 0 && !chain) tx_valid[d] = 1'b0;
      if (n == gj) begin
        tx_valid[d] = 1'b1;
        tx_data[d]  = 8'hFF;
      end else if (n == gj + 1) begin
        tx_valid[d] = 1'b0;
        tx_data[d]  = 8'($urandom);
      end else begin
        tx_data[d]  = 8'($urandom);
      end
      samp_q.push_back(tx_w[d]);
      check_eq($sformatf("d%0d_%02h_cyc%0d_bit%0d", d, data, n, n / c),
               32'({tx_w[d], transmitting_w[d], tx_ready_w[d], transmitted_w[d]}),
               32'({frame_bit(d, data, n / c), 1'b1, 1'b0, 1'b0}));
    end
    @(negedge clk);
    check_eq($sformatf("d%0d_%02h_end", d, data),
             32'({tx_w[d], transmitting_w[d], tx_ready_w[d], transmitted_w[d]}), 32'(4'b1011));
    // Receiver-style recovery from bit-centre samples.
    got_b = 8'd0;
    for (int i = 0; i < 8; i++) got_b[i] = samp_q[(i + 1) * c + c / 2];
    check_eq($sformatf("d%0d_loopback", d), 32'(got_b), 32'(data));
    check_eq($sformatf("d%0d_stop_centre", d), 32'(samp_q[(f - 1) * c + c / 2]), 32'd1);
    if (chain) begin
      tx_data[d] = nxt;
    end else begin
      @(negedge clk);
      check_eq($sformatf("d%0d_idle_after", d),
               32'({tx_w[d], transmitting_w[d], tx_ready_w[d], transmitted_w[d]}), 32'(4'b1010));
    end
  endtask

  task automatic reset_mid(input int d);
    int c, dc;
    c = cfg_c(d);
    offer(d, 8'($urandom));
    @(posedge clk);
    @(negedge clk);
    tx_valid[d] = 1'b0;
    repeat (4 * c + 1) @(negedge clk);
    check_eq($sformatf("d%0d_busy_before_rst", d), 32'(transmitting_w[d]), 32'd1);
    dc = done_cnt[d];
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    check_eq($sformatf("d%0d_rst_mid", d),
             32'({tx_w[d], transmitting_w[d], tx_ready_w[d], transmitted_w[d]}), 32'(4'b1010));
    repeat (2) @(negedge clk);
    check_eq($sformatf("d%0d_rst_idle", d),
             32'({tx_w[d], transmitting_w[d], tx_ready_w[d], transmitted_w[d]}), 32'(4'b1010));
    check_eq($sformatf("d%0d_rst_no_pulse", d), 32'(done_cnt[d] - dc), 32'd0);
    offer(d, 8'h3C);
    run_frame(d, 8'h3C, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pat;
    logic [7:0] lb [4];
    logic [7:0] b0, b1;
    int d, dc;

    rst      = 3'b111;
    tx_valid = 3'b000;
    for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("d%0d_reset", i),
               32'({tx_w[i], transmitting_w[i], tx_ready_w[i], transmitted_w[i]}), 32'(4'b1010));
    rst = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("d%0d_post_reset", i),
               32'({tx_w[i], transmitting_w[i], tx_ready_w[i], transmitted_w[i]}), 32'(4'b1010));

    // Basic frame 0xA5 with an explicit bit-pattern check.
    offer(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) pat[k] = samp_q[k * 4 + 2];
    check_eq("a5_pattern", 32'(pat), 32'(10'b1_1010_0101_0));

    // Even parity, two stop bits.
    offer(1, 8'h07);
    run_frame(1, 8'h07, 1'b0, 8'h00, 1'b0);
    check_eq("par_07", 32'(samp_q[9 * 4 + 2]), 32'd1);
    offer(1, 8'h03);
    run_frame(1, 8'h03, 1'b0, 8'h00, 1'b0);
    check_eq("par_03", 32'(samp_q[9 * 4 + 2]), 32'd0);

    // Back-to-back with tx_valid held.
    dc = done_cnt[0];
    offer(0, 8'h55);
    run_frame(0, 8'h55, 1'b1, 8'h0F, 1'b0);
    run_frame(0, 8'h0F, 1'b0, 8'h00, 1'b0);
    check_eq("b2b_pulses", 32'(done_cnt[0] - dc), 32'd2);

    // Offer while busy is ignored.
    dc = done_cnt[0];
    offer(0, 8'h00);
    run_frame(0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("glitch_pulses", 32'(done_cnt[0] - dc), 32'd1);
    check_eq("glitch_idle", 32'(transmitting_w[0]), 32'd0);

    reset_mid(0);
    reset_mid(2);

    // Loopback sequence on the odd-parity instance.
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'h81;
    dc = done_cnt[2];
    for (int i = 0; i < 4; i++) begin
      offer(2, lb[i]);
      run_frame(2, lb[i], 1'b0, 8'h00, 1'b0);
    end
    check_eq("loop_pulses", 32'(done_cnt[2] - dc), 32'd4);

    // Randomized frames across all configurations.
    for (int it = 0; it < 12; it++) begin
      d  = $urandom_range(2, 0);
      b0 = 8'($urandom);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      offer(d, b0);
      run_frame(d, b0, 1'b0, 8'h00, 1'($urandom_range(1, 0)));
    end
    for (int it = 0; it < 3; it++) begin
      d  = it;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      dc = done_cnt[d];
      offer(d, b0);
      run_frame(d, b0, 1'b1, b1, 1'b0);
      run_frame(d, b1, 1'b0, 8'h00, 1'b0);
      check_eq($sformatf("d%0d_rand_b2b_pulses", d), 32'(done_cnt[d] - dc), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
